muldiv_ctrl: RTL and testbench



---
 rtl/muldiv_pkg.sv | 18 +
 rtl/muldiv_ctrl.sv | 143 ++++++++++++++
 tb/tb_muldiv_ctrl.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// Shared encodings for the EX-stage multiply/divide sequencing controller.
package muldiv_pkg;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_MUL_WAIT = 2'd1,
    S_DIV_RUN  = 2'd2,
    S_DONE     = 2'd3
  } state_t;

  localparam int OP_DIV   = 3;
  localparam int OP_DIVU  = 2;
  localparam int OP_MULT  = 1;
  localparam int OP_MULTU = 0;

  localparam int MUL_LAT_DEF = 2;

endpackage

// File: rtl/muldiv_ctrl.sv
// Launches one mult/div at a time on the external multiplier or divider,
// stalls EX until the result is captured, then presents a one-shot HI/LO write.
module muldiv_ctrl
  import muldiv_pkg::*;
#(
  parameter int MUL_LAT = MUL_LAT_DEF
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        op_valid,
  input  logic [3:0]  op_code,
  input  logic [31:0] op_src1,
  input  logic [31:0] op_src2,
  input  logic        flush,
  input  logic        stall_after,
  output logic        stallreq,
  output logic        mul_signed,
  output logic [31:0] mul_ina,
  output logic [31:0] mul_inb,
  input  logic [63:0] mul_result,
  output logic        div_start,
  output logic        div_signed,
  output logic        div_annul,
  output logic [31:0] div_opdata1,
  output logic [31:0] div_opdata2,
  input  logic        div_ready,
  input  logic [63:0] div_result,
  output logic        hi_we,
  output logic        lo_we,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        busy
);

  localparam logic [2:0] LAT_LAST = 3'(MUL_LAT);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [2:0]  r_cnt;
  logic [31:0] r_src1;
  logic [31:0] r_src2;
  logic        r_signed;
  logic [31:0] r_hi;
  logic [31:0] r_lo;

  logic w_launch;
  logic w_dec_div;
  logic w_dec_signed;
  logic w_div_zero;
  logic w_mul_last;

  // Priority div > divu > mult > multu when several op_code bits are set.
  always_comb begin
    w_dec_div    = op_code[OP_DIV] | op_code[OP_DIVU];
    w_dec_signed = op_code[OP_DIV] | (~op_code[OP_DIVU] & op_code[OP_MULT]);
    w_div_zero   = w_dec_div && (op_src2 == 32'd0);
    w_launch     = resetn && (r_state == S_IDLE) && op_valid && (|op_code) && !flush;
    w_mul_last   = (r_cnt == LAT_LAST);
  end

  always_comb begin
    w_state_nxt = r_state;
    div_start   = 1'b0;
    div_annul   = 1'b0;
    hi_we       = 1'b0;
    lo_we       = 1'b0;
    hi_o        = 32'd0;
    lo_o        = 32'd0;
    case (r_state)
      S_IDLE: begin
        if (w_launch) begin
          if (!w_dec_div)     w_state_nxt = S_MUL_WAIT;
          else if (w_div_zero) w_state_nxt = S_DONE;
          else                w_state_nxt = S_DIV_RUN;
        end
      end
      S_MUL_WAIT: begin
        if (w_mul_last) w_state_nxt = S_DONE;
      end
      S_DIV_RUN: begin
        if (div_ready) w_state_nxt = S_DONE;
        else           div_start   = 1'b1;
      end
      S_DONE: begin
        hi_we = 1'b1;
        lo_we = 1'b1;
        hi_o  = r_hi;
        lo_o  = r_lo;
        if (!stall_after) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (flush) begin
      w_state_nxt = S_IDLE;
      div_start   = 1'b0;
      hi_we       = 1'b0;
      lo_we       = 1'b0;
      div_annul   = (r_state == S_DIV_RUN);
    end
  end

  always_comb begin
    stallreq    = w_launch || (r_state == S_MUL_WAIT) || (r_state == S_DIV_RUN);
    busy        = (r_state != S_IDLE);
    mul_signed  = r_signed;
    mul_ina     = r_src1;
    mul_inb     = r_src2;
    div_signed  = r_signed;
    div_opdata1 = r_src1;
    div_opdata2 = r_src2;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state  <= S_IDLE;
      r_cnt    <= 3'd0;
      r_src1   <= 32'd0;
      r_src2   <= 32'd0;
      r_signed <= 1'b0;
      r_hi     <= 32'd0;
      r_lo     <= 32'd0;
    end else begin
      r_state <= w_state_nxt;
      if (flush)                                     r_cnt <= 3'd0;
      else if (w_launch)                             r_cnt <= 3'd1;
      else if (r_state == S_MUL_WAIT && !w_mul_last) r_cnt <= r_cnt + 3'd1;
      else                                           r_cnt <= 3'd0;
      if (w_launch) begin
        r_src1   <= op_src1;
        r_src2   <= op_src2;
        r_signed <= w_dec_signed;
      end
      // Divide-by-zero skips the divider and writes HI=LO=0.
      if (w_launch && w_div_zero)
        {r_hi, r_lo} <= 64'd0;
      else if (!flush && r_state == S_MUL_WAIT && w_mul_last)
        {r_hi, r_lo} <= mul_result;
      else if (!flush && r_state == S_DIV_RUN && div_ready)
        {r_hi, r_lo} <= div_result;
    end
  end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Randomized transaction-level bench for muldiv_ctrl with behavioural mul/div units.
module tb_muldiv_ctrl;

  localparam int ML = 2;

  logic        clk = 1'b0;
  logic        resetn;
  logic        op_valid;
  logic [3:0]  op_code;
  logic [31:0] op_src1, op_src2;
  logic        flush, stall_after;
  logic        stallreq;
  logic        mul_signed;
  logic [31:0] mul_ina, mul_inb;
  logic [63:0] mul_result;
  logic        div_start, div_signed, div_annul;
  logic [31:0] div_opdata1, div_opdata2;
  logic        div_ready;
  logic [63:0] div_result;
  logic        hi_we, lo_we;
  logic [31:0] hi_o, lo_o;
  logic        busy;

  int n_chk  = 0;
  int n_fail = 0;

  logic        chk_en = 1'b0;
  logic        e_stall, e_busy, e_start, e_annul, e_we;
  logic [31:0] e_hi, e_lo;
  logic [31:0] m_hi, m_lo;

  muldiv_ctrl #(.MUL_LAT(ML)) dut (
    .clk(clk), .resetn(resetn), .op_valid(op_valid), .op_code(op_code),
    .op_src1(op_src1), .op_src2(op_src2), .flush(flush), .stall_after(stall_after),
    .stallreq(stallreq), .mul_signed(mul_signed), .mul_ina(mul_ina), .mul_inb(mul_inb),
    .mul_result(mul_result), .div_start(div_start), .div_signed(div_signed),
    .div_annul(div_annul), .div_opdata1(div_opdata1), .div_opdata2(div_opdata2),
    .div_ready(div_ready), .div_result(div_result), .hi_we(hi_we), .lo_we(lo_we),
    .hi_o(hi_o), .lo_o(lo_o), .busy(busy)
  );

  always #5 clk = ~clk;

  // Plain arithmetic: product {hi,lo} or {remainder,quotient}.
  function automatic logic [63:0] arith(input logic is_div, input logic sgn,
                                        input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb;
    logic [63:0] ua, ub, q, r;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'd0, a};
    ub = {32'd0, b};
    if (is_div) begin
      if (b == 32'd0) return 64'd0;
      if (sgn) begin q = sa / sb; r = sa % sb; end
      else     begin q = ua / ub; r = ua % ub; end
      return {r[31:0], q[31:0]};
    end
    if (sgn) return sa * sb;
    return ua * ub;
  endfunction

  function automatic logic [63:0] ref_res(input logic [3:0] opc, input logic [31:0] a,
                                          input logic [31:0] b);
    if (opc[3])      return arith(1'b1, 1'b1, a, b);
    else if (opc[2]) return arith(1'b1, 1'b0, a, b);
    else if (opc[1]) return arith(1'b0, 1'b1, a, b);
    return arith(1'b0, 1'b0, a, b);
  endfunction

  always_comb mul_result = arith(1'b0, mul_signed, mul_ina, mul_inb);
  always_comb div_result = arith(1'b1, div_signed, div_opdata1, div_opdata2);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%08h expected 0x%08h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("stallreq",  32'(stallreq),  32'(e_stall));
      chk("busy",      32'(busy),      32'(e_busy));
      chk("div_start", 32'(div_start), 32'(e_start));
      chk("div_annul", 32'(div_annul), 32'(e_annul));
      chk("hi_we",     32'(hi_we),     32'(e_we));
      chk("lo_we",     32'(lo_we),     32'(e_we));
      chk("hi_o",      hi_o,           e_hi);
      chk("lo_o",      lo_o,           e_lo);
    end
  end

  task automatic set_exp(input logic sr, input logic bz, input logic st, input logic an,
                         input logic we, input logic [31:0] hi, input logic [31:0] lo);
    e_stall = sr; e_busy = bz; e_start = st; e_annul = an; e_we = we; e_hi = hi; e_lo = lo;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One IDLE cycle whose inputs must not cause a launch.
  task automatic idle_cyc(input logic ov, input logic [3:0] opc, input logic fl);
    op_valid = ov; op_code = opc; flush = fl; stall_after = 1'b0; div_ready = 1'b0;
    op_src1 = $urandom; op_src2 = $urandom;
    set_exp(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    step();
    flush = 1'b0;
  endtask

  // fmode: 0 none, 1 flush at run cycle fk, 2 flush at DONE cycle fk.
  task automatic do_op(input logic [3:0] opc, input logic [31:0] a, input logic [31:0] b,
                       input int dlat, input int sa, input int fmode, input int fk);
    logic is_div, dz, last, fl;
    logic [63:0] res;
    int runlen;
    is_div = opc[3] | opc[2];
    dz     = is_div && (b == 32'd0);
    res    = ref_res(opc, a, b);
    m_hi   = res[63:32];
    m_lo   = res[31:0];
    op_valid = 1'b1; op_code = opc; op_src1 = a; op_src2 = b;
    flush = 1'b0; stall_after = 1'b0; div_ready = 1'b0;
    set_exp(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    step();
    runlen = dz ? 0 : (is_div ? dlat + 1 : ML);
    for (int c = 1; c <= runlen; c++) begin
      last = (c == runlen);
      fl   = (fmode == 1) && (c == fk);
      op_src1 = $urandom; op_src2 = $urandom;
      flush = fl;
      div_ready = is_div && last;
      set_exp(1'b1, 1'b1, is_div && !last && !fl, is_div && fl, 1'b0, 32'd0, 32'd0);
      step();
      if (fl) begin
        flush = 1'b0; op_valid = 1'b0; op_code = 4'd0; div_ready = 1'b0;
        return;
      end
    end
    for (int d = 0; d <= sa; d++) begin
      fl = (fmode == 2) && (d == fk);
      op_src1 = $urandom; op_src2 = $urandom;
      flush = fl; stall_after = (d < sa); div_ready = 1'b0;
      set_exp(1'b0, 1'b1, 1'b0, 1'b0, !fl, m_hi, m_lo);
      step();
      if (fl) break;
    end
    flush = 1'b0; stall_after = 1'b0; op_valid = 1'b0; op_code = 4'd0;
  endtask

  initial begin
    logic [3:0]  opc;
    logic [31:0] a, b;
    int dlat, sa, fm, fmode, fk, gap, kind;
    resetn = 1'b0; op_valid = 1'b0; op_code = 4'd0; op_src1 = 32'd0; op_src2 = 32'd0;
    flush = 1'b0; stall_after = 1'b0; div_ready = 1'b0;
    set_exp(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    #12;
    chk("rst_stallreq", 32'(stallreq), 32'd0);
    chk("rst_busy",     32'(busy),     32'd0);
    chk("rst_hi_we",    32'(hi_we),    32'd0);
    chk("rst_mul_ina",  mul_ina,       32'd0);
    @(posedge clk); #1;
    resetn = 1'b1;
    chk_en = 1'b1;
    idle_cyc(1'b0, 4'd0, 1'b0);

    // mult / multu with MUL_LAT=2, back to back
    do_op(4'b0010, 32'hFFFF_FFFF, 32'd2, 0, 0, 0, 0);
    chk("pin_mult_hi", m_hi, 32'hFFFF_FFFF);
    chk("pin_mult_lo", m_lo, 32'hFFFF_FFFE);
    do_op(4'b0001, 32'hFFFF_FFFF, 32'd2, 0, 0, 0, 0);
    chk("pin_multu_hi", m_hi, 32'h0000_0001);
    chk("pin_multu_lo", m_lo, 32'hFFFF_FFFE);
    idle_cyc(1'b0, 4'd0, 1'b0);

    // divu 100/7 with divider ready after 33 cycles
    do_op(4'b0100, 32'd100, 32'd7, 33, 0, 0, 0);
    chk("pin_divu_hi", m_hi, 32'd2);
    chk("pin_divu_lo", m_lo, 32'd14);

    // div by zero, then signed div with negative dividend
    do_op(4'b1000, 32'h8000_0000, 32'd0, 5, 0, 0, 0);
    chk("pin_dz_hi", m_hi, 32'd0);
    do_op(4'b1000, 32'hFFFF_FF9C, 32'd7, 4, 0, 0, 0);
    chk("pin_div_hi", m_hi, 32'hFFFF_FFFE);
    chk("pin_div_lo", m_lo, 32'hFFFF_FFF2);

    // flush at cycle 10 of a divide, then a mult on the next cycle
    do_op(4'b1000, 32'd12345, 32'd11, 33, 0, 1, 10);
    do_op(4'b0010, 32'd3, 32'hFFFF_FFFB, 0, 0, 0, 0);

    // DONE held by stall_after for 4 cycles
    do_op(4'b0010, 32'd6, 32'd7, 0, 4, 0, 0);
    chk("pin_mult_small", m_lo, 32'd42);

    // multi-hot priority and flush suppressing a launch
    do_op(4'b0111, 32'd50, 32'd8, 3, 1, 0, 0);
    idle_cyc(1'b1, 4'b0010, 1'b1);
    idle_cyc(1'b1, 4'b0000, 1'b0);

    for (int i = 0; i < 40; i++) begin
      opc = 4'($urandom_range(1, 15));
      a = $urandom;
      b = ($urandom_range(0, 5) == 0) ? 32'd0 : (($urandom_range(0, 1) == 0) ? $urandom : 32'($urandom_range(1, 20)));
      dlat = $urandom_range(1, 12);
      sa = $urandom_range(0, 3);
      fm = $urandom_range(0, 5);
      fmode = (fm < 4) ? 0 : fm - 3;
      if (fmode == 1) fk = $urandom_range(1, (opc[3] | opc[2]) ? dlat + 1 : ML);
      else            fk = $urandom_range(0, sa);
      do_op(opc, a, b, dlat, sa, fmode, fk);
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        kind = $urandom_range(0, 2);
        if (kind == 0)      idle_cyc(1'b0, 4'($urandom), 1'b0);
        else if (kind == 1) idle_cyc(1'b1, 4'd0, 1'b0);
        else                idle_cyc(1'b1, 4'($urandom_range(1, 15)), 1'b1);
      end
    end

    // asynchronous reset in the middle of a divide
    op_valid = 1'b1; op_code = 4'b0100; op_src1 = 32'd999; op_src2 = 32'd5;
    set_exp(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    step();
    set_exp(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
    step();
    step();
    chk_en = 1'b0;
    op_valid = 1'b0; op_code = 4'd0;
    #1 resetn = 1'b0;
    #1;
    chk("arst_div_start", 32'(div_start),   32'd0);
    chk("arst_stallreq",  32'(stallreq),    32'd0);
    chk("arst_busy",      32'(busy),        32'd0);
    chk("arst_opdata1",   div_opdata1,      32'd0);
    chk("arst_hi_we",     32'(hi_we),       32'd0);
    @(posedge clk); #1;
    resetn = 1'b1;
    chk_en = 1'b1;
    idle_cyc(1'b0, 4'd0, 1'b0);
    do_op(4'b0001, 32'h1234_5678, 32'h0000_0010, 0, 0, 0, 0);
    idle_cyc(1'b0, 4'd0, 1'b0);
    chk_en = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
